// File: rtl/seq_calculator.sv
// Sign-magnitude sequential ALU: add/sub in one compute step, iterative
// shift-add multiply and restoring divide over W steps, Start/Busy/Done.
//
// Ports:
//   Clk, Rst_n          clock, async active-low reset
//   Start, Sel          request and op (00 add, 01 sub, 10 mul, 11 div)
//   A, B, Sign_A/B      operand magnitudes and signs (1 = negative)
//   Busy, Done          in-progress flag, one-cycle completion pulse
//   Out, Out_sign       result magnitude and sign
//   R, R_sign           remainder magnitude and sign (div only)
//   Ovf, Div_zero       add/sub carry or mul high half nonzero; div by 0
module seq_calculator #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Start,
    input  logic [1:0]   Sel,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Sign_A,
    input  logic         Sign_B,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Out,
    output logic         Out_sign,
    output logic [W-1:0] R,
    output logic         R_sign,
    output logic         Ovf,
    output logic         Div_zero
);

    localparam int CNT_W = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t st;

    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             sa_r;
    logic             sb_r;
    logic [1:0]       sel_r;

    logic [2*W-1:0]   prod;
    logic [W-1:0]     quo;
    logic [W-1:0]     rem;

    // Add/sub datapath on captured operands
    logic             sb_eff;
    logic [W:0]       add_sum;
    logic [W-1:0]     add_out;
    logic             add_sign;
    logic             add_ovf;

    always_comb begin
        sb_eff   = sel_r[0] ? ~sb_r : sb_r;
        add_sum  = {1'b0, a_r} + {1'b0, b_r};
        add_out  = '0;
        add_sign = 1'b0;
        add_ovf  = 1'b0;
        if (sa_r == sb_eff) begin
            add_out  = add_sum[W-1:0];
            add_ovf  = add_sum[W];
            add_sign = sa_r;
        end else if (a_r >= b_r) begin
            add_out  = a_r - b_r;
            add_sign = sa_r;
        end else begin
            add_out  = b_r - a_r;
            add_sign = sb_eff;
        end
        if (add_out == '0) begin
            add_sign = 1'b0;
        end
    end

    // One shift-add step: multiplier sits in the low half of prod and is
    // consumed LSB first while partial sums enter from the top.
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   prod_nx;

    always_comb begin
        mul_sum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, a_r} : '0);
        prod_nx = {mul_sum, prod[W-1:1]};
    end

    // One restoring-division step: dividend bits shift out of quo's MSB
    // into rem, and quotient bits shift in at quo's LSB.
    logic [W:0]       div_t;
    logic [W-1:0]     rem_nx;
    logic [W-1:0]     quo_nx;

    always_comb begin
        div_t = {rem, quo[W-1]};
        if (div_t >= {1'b0, b_r}) begin
            rem_nx = W'(div_t - {1'b0, b_r});
            quo_nx = {quo[W-2:0], 1'b1};
        end else begin
            rem_nx = div_t[W-1:0];
            quo_nx = {quo[W-2:0], 1'b0};
        end
    end

    // cnt == 0 is the staging cycle that loads the iterative registers;
    // add/sub and div-by-zero finish on the following cycle.
    logic is_short;
    logic last;

    always_comb begin
        is_short = ~sel_r[1] | (sel_r[0] & (b_r == '0));
        last     = is_short ? (cnt == CNT_W'(1)) : (cnt == CNT_W'(W));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            st       <= IDLE;
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            sel_r    <= 2'b00;
            prod     <= '0;
            quo      <= '0;
            rem      <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Out      <= '0;
            Out_sign <= 1'b0;
            R        <= '0;
            R_sign   <= 1'b0;
            Ovf      <= 1'b0;
            Div_zero <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (st)
                IDLE, DONE: begin
                    if (Start) begin
                        a_r   <= A;
                        b_r   <= B;
                        sa_r  <= Sign_A;
                        sb_r  <= Sign_B;
                        sel_r <= Sel;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        st    <= CALC;
                    end else begin
                        st <= IDLE;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == '0) begin
                        prod <= {{W{1'b0}}, b_r};
                        quo  <= a_r;
                        rem  <= '0;
                    end else begin
                        prod <= prod_nx;
                        quo  <= quo_nx;
                        rem  <= rem_nx;
                    end
                    if (last) begin
                        st       <= DONE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Ovf      <= 1'b0;
                        Div_zero <= 1'b0;
                        R        <= '0;
                        R_sign   <= 1'b0;
                        unique case (sel_r)
                            2'b00, 2'b01: begin
                                Out      <= add_out;
                                Out_sign <= add_sign;
                                Ovf      <= add_ovf;
                            end
                            2'b10: begin
                                Out      <= prod_nx[W-1:0];
                                Out_sign <= (sa_r ^ sb_r) & (|prod_nx[W-1:0]);
                                Ovf      <= |prod_nx[2*W-1:W];
                            end
                            default: begin
                                if (b_r == '0) begin
                                    Out      <= '0;
                                    Out_sign <= 1'b0;
                                    Div_zero <= 1'b1;
                                end else begin
                                    Out      <= quo_nx;
                                    Out_sign <= (sa_r ^ sb_r) & (|quo_nx);
                                    R        <= rem_nx;
                                    R_sign   <= sa_r & (|rem_nx);
                                end
                            end
                        endcase
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed self-checking bench for seq_calculator (W = 8).
// Each scenario task drives stimulus and checks results inline.
module tb_seq_calculator;

    logic       Clk;
    logic       Rst_n;
    logic       Start;
    logic [1:0] Sel;
    logic [7:0] A;
    logic [7:0] B;
    logic       Sign_A;
    logic       Sign_B;
    logic       Busy;
    logic       Done;
    logic [7:0] Out;
    logic       Out_sign;
    logic [7:0] R;
    logic       R_sign;
    logic       Ovf;
    logic       Div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_calculator #(.W(8)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .Sel      (Sel),
        .A        (A),
        .B        (B),
        .Sign_A   (Sign_A),
        .Sign_B   (Sign_B),
        .Busy     (Busy),
        .Done     (Done),
        .Out      (Out),
        .Out_sign (Out_sign),
        .R        (R),
        .R_sign   (R_sign),
        .Ovf      (Ovf),
        .Div_zero (Div_zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one op, pulse Start for one edge, return edges until Done (-1 on timeout)
    task automatic run_op(input logic [1:0] s, input logic sa, input logic [7:0] a,
                          input logic sb, input logic [7:0] b, output int lat);
        @(negedge Clk);
        Sel = s; Sign_A = sa; A = a; Sign_B = sb; B = b; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        Rst_n = 1'b0; Start = 1'b0; Sel = 2'b00;
        A = 8'd0; B = 8'd0; Sign_A = 1'b0; Sign_B = 1'b0;
        #12;
        n_checks++;
        if ({Busy, Done, Out, Out_sign, R, R_sign, Ovf, Div_zero} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0",
                     {Busy, Done, Out, Out_sign, R, R_sign, Ovf, Div_zero});
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if ({Busy, Done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_quiet got=%b want=00", {Busy, Done});
        end
    endtask

    task automatic test_add;
        int lat;
        run_op(2'b00, 1'b0, 8'd100, 1'b0, 8'd27, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency got=%0d want=2", lat); end
        n_checks++;
        if ({Out_sign, Out, Ovf} !== {1'b0, 8'd127, 1'b0}) begin
            n_fail++;
            $display("FAIL add_127 got s=%b out=%0d ovf=%b want s=0 out=127 ovf=0", Out_sign, Out, Ovf);
        end
        @(posedge Clk);
        #1;
        n_checks++;
        if ({Done, Out} !== {1'b0, 8'd127}) begin
            n_fail++;
            $display("FAIL done_pulse_hold got done=%b out=%0d want done=0 out=127", Done, Out);
        end
        run_op(2'b00, 1'b0, 8'd200, 1'b0, 8'd100, lat);
        n_checks++;
        if ({Out_sign, Out, Ovf} !== {1'b0, 8'd44, 1'b1}) begin
            n_fail++;
            $display("FAIL add_ovf got s=%b out=%0d ovf=%b want s=0 out=44 ovf=1", Out_sign, Out, Ovf);
        end
    endtask

    task automatic test_sub;
        int lat;
        run_op(2'b01, 1'b1, 8'd5, 1'b0, 8'd3, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL sub_latency got=%0d want=2", lat); end
        n_checks++;
        if ({Out_sign, Out, Ovf} !== {1'b1, 8'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_neg8 got s=%b out=%0d ovf=%b want s=1 out=8 ovf=0", Out_sign, Out, Ovf);
        end
        run_op(2'b01, 1'b0, 8'd7, 1'b0, 8'd7, lat);
        n_checks++;
        if ({Out_sign, Out} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL sub_zero got s=%b out=%0d want s=0 out=0", Out_sign, Out);
        end
        run_op(2'b01, 1'b0, 8'd3, 1'b0, 8'd10, lat);
        n_checks++;
        if ({Out_sign, Out, Ovf} !== {1'b1, 8'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_swap got s=%b out=%0d ovf=%b want s=1 out=7 ovf=0", Out_sign, Out, Ovf);
        end
    endtask

    task automatic test_mul;
        int lat;
        run_op(2'b10, 1'b0, 8'd12, 1'b1, 8'd11, lat);
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL mul_latency got=%0d want=9", lat); end
        n_checks++;
        if ({Out_sign, Out, Ovf, R} !== {1'b1, 8'd132, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL mul_132 got s=%b out=%0d ovf=%b r=%0d want s=1 out=132 ovf=0 r=0",
                     Out_sign, Out, Ovf, R);
        end
        run_op(2'b10, 1'b0, 8'd20, 1'b0, 8'd20, lat);
        n_checks++;
        if ({Out_sign, Out, Ovf} !== {1'b0, 8'd144, 1'b1}) begin
            n_fail++;
            $display("FAIL mul_ovf got s=%b out=%0d ovf=%b want s=0 out=144 ovf=1", Out_sign, Out, Ovf);
        end
    endtask

    task automatic test_capture;
        int first;
        int dones;
        first = -1;
        dones = 0;
        @(negedge Clk);
        Sel = 2'b10; Sign_A = 1'b0; A = 8'd12; Sign_B = 1'b1; B = 8'd11; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                dones++;
                if (first < 0) first = k;
            end
            if (k == 3) begin A = 8'd99; Start = 1'b1; end
            if (k == 4) Start = 1'b0;
        end
        n_checks++;
        if (first !== 9) begin n_fail++; $display("FAIL capture_latency got=%0d want=9", first); end
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL capture_dones got=%0d want=1", dones); end
        n_checks++;
        if ({Out_sign, Out} !== {1'b1, 8'd132}) begin
            n_fail++;
            $display("FAIL capture_result got s=%b out=%0d want s=1 out=132", Out_sign, Out);
        end
    endtask

    task automatic test_div;
        int lat;
        run_op(2'b11, 1'b1, 8'd100, 1'b0, 8'd7, lat);
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL div_latency got=%0d want=9", lat); end
        n_checks++;
        if ({Out_sign, Out, R_sign, R, Div_zero} !== {1'b1, 8'd14, 1'b1, 8'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL div_100_7 got s=%b q=%0d rs=%b r=%0d dz=%b want s=1 q=14 rs=1 r=2 dz=0",
                     Out_sign, Out, R_sign, R, Div_zero);
        end
        run_op(2'b11, 1'b0, 8'd9, 1'b0, 8'd0, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL divz_latency got=%0d want=2", lat); end
        n_checks++;
        if ({Div_zero, Out, R, Out_sign, R_sign} !== {1'b1, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL div_zero got dz=%b q=%0d r=%0d want dz=1 q=0 r=0", Div_zero, Out, R);
        end
        run_op(2'b00, 1'b0, 8'd1, 1'b0, 8'd1, lat);
        n_checks++;
        if ({Div_zero, R, R_sign, Out} !== {1'b0, 8'd0, 1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL flags_cleared got dz=%b r=%0d rs=%b out=%0d want dz=0 r=0 rs=0 out=2",
                     Div_zero, R, R_sign, Out);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge Clk);
        Sel = 2'b00; Sign_A = 1'b0; A = 8'd1; Sign_B = 1'b0; B = 8'd2; Start = 1'b1;
        @(posedge Clk);
        lat = -1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge Clk);
            #1;
            if (Done) begin lat = k; break; end
        end
        n_checks++;
        if ({lat, Out} !== {32'sd2, 8'd3}) begin
            n_fail++;
            $display("FAIL b2b_first got lat=%0d out=%0d want lat=2 out=3", lat, Out);
        end
        A = 8'd5; B = 8'd6;
        @(posedge Clk);
        #1;
        n_checks++;
        if ({Busy, Done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_no_idle got busy=%b done=%b want busy=1 done=0", Busy, Done);
        end
        Start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge Clk);
            #1;
            if (Done) begin lat = k; break; end
        end
        n_checks++;
        if ({lat, Out} !== {32'sd2, 8'd11}) begin
            n_fail++;
            $display("FAIL b2b_second got lat=%0d out=%0d want lat=2 out=11", lat, Out);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int dones;
        dones = 0;
        @(negedge Clk);
        Sel = 2'b10; Sign_A = 1'b0; A = 8'd12; Sign_B = 1'b1; B = 8'd11; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (4) @(posedge Clk);
        #3 Rst_n = 1'b0;
        #1;
        n_checks++;
        if ({Busy, Done, Out, Out_sign, R, R_sign, Ovf, Div_zero} !== 22'd0) begin
            n_fail++;
            $display("FAIL midreset_clear got=%h want=0",
                     {Busy, Done, Out, Out_sign, R, R_sign, Ovf, Div_zero});
        end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk);
            #1;
            if (Done || Busy) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_done got=%0d want=0", dones);
        end
        run_op(2'b00, 1'b0, 8'd100, 1'b0, 8'd27, lat);
        n_checks++;
        if ({lat, Out} !== {32'sd2, 8'd127}) begin
            n_fail++;
            $display("FAIL after_reset got lat=%0d out=%0d want lat=2 out=127", lat, Out);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_capture();
        test_div();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
